// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter, and later the receiver.
// With UART_TX_PARITY_EN defined, the PARITY_BIT state exists.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY_BIT = 3'd3,
`endif
    STOP_BIT   = 3'd4
  } uart_tx_state_t;

  function automatic int clocks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: runs 0..CLOCKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_counter #(
  parameter int CLOCKS_PER_BIT = 16
) (
  input  logic ACLK,
  input  logic RESET,
  input  logic clear,
  input  logic inc,
  output logic terminal_count
);

  localparam int CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLOCKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal_count = (count_q == LAST_COUNT);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding register for gap-free back-to-back frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       ACLK,
  input  logic       RESET,
  input  logic [7:0] TX_DATA,
  input  logic       TX_DATA_VALID,
  output logic       TX_READY,
  output logic       TXD,
  output logic       TX_BUSY
);

  localparam int CLOCKS_PER_BIT = clocks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  if (CLOCKS_PER_BIT < 2) begin : g_cpb_check
    $error("uart_tx: CLOCKS_PER_BIT must be at least 2, got %0d", CLOCKS_PER_BIT);
  end

  uart_tx_state_t state_q, state_d;
  logic [7:0]     hold_q, hold_d;
  logic           hold_full_q, hold_full_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic           txd_q, txd_d;
  logic           tx_ready_q, tx_ready_d;
  logic           cnt_clear, cnt_inc, cnt_tc, load_shift;

  uart_baud_counter #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_baud_counter (
    .ACLK          (ACLK),
    .RESET         (RESET),
    .clear         (cnt_clear),
    .inc           (cnt_inc),
    .terminal_count(cnt_tc)
  );

  // TXD is registered, so it is derived from the state being entered, not the current one.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    cnt_clear   = 1'b0;
    cnt_inc     = 1'b0;
    load_shift  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_clear = 1'b1;
        if (hold_full_q) begin
          load_shift = 1'b1;
          state_d    = START_BIT;
        end
      end
      START_BIT: begin
        if (cnt_tc) begin
          cnt_clear = 1'b1;
          bit_idx_d = '0;
          state_d   = DATA_BITS;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DATA_BITS: begin
        if (cnt_tc) begin
          cnt_clear = 1'b1;
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY_BIT;
`else
            state_d   = STOP_BIT;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY_BIT: begin
        if (cnt_tc) begin
          cnt_clear = 1'b1;
          state_d   = STOP_BIT;
        end else begin
          cnt_inc = 1'b1;
        end
      end
`endif
      STOP_BIT: begin
        if (cnt_tc) begin
          cnt_clear = 1'b1;
          if (hold_full_q) begin
            load_shift = 1'b1;
            state_d    = START_BIT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        cnt_clear = 1'b1;
        state_d   = IDLE;
      end
    endcase

    if (load_shift) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
    end
    // tx_ready_q is low whenever the holder is full, so this never collides with load_shift.
    if (TX_DATA_VALID && tx_ready_q) begin
      hold_d      = TX_DATA;
      hold_full_d = 1'b1;
    end
    tx_ready_d = !hold_full_d;

    txd_d = UART_IDLE_LEVEL;
    case (state_d)
      START_BIT:  txd_d = 1'b0;
      DATA_BITS:  txd_d = shift_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
      PARITY_BIT: txd_d = ^shift_d;
`endif
      default:    txd_d = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      txd_q       <= UART_IDLE_LEVEL;
      tx_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      txd_q       <= txd_d;
      tx_ready_q  <= tx_ready_d;
    end
  end

  assign TXD      = txd_q;
  assign TX_READY = tx_ready_q;
  assign TX_BUSY  = (state_q != IDLE) || hold_full_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a cycle-level line-waveform model plus an independent
// mid-bit line decoder. Honours UART_TX_PARITY_EN when defined.
module tb_uart_tx;

  localparam int CLOCK_FREQ = 1000;
  localparam int BAUD_RATE  = 100;
  localparam int CPB        = CLOCK_FREQ / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       ACLK = 1'b0;
  logic       RESET = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_data_valid = 1'b0;
  logic       tx_ready, txd, tx_busy;

  int error_count = 0;
  int check_count = 0;

  // Model: expected TXD level for each future cycle, plus the holding-register occupancy.
  logic       m_line[$];
  logic       m_held = 1'b0;
  logic [7:0] m_hold_byte = 8'h00;

  logic [7:0] pending_q[$];
  logic [7:0] sent_q[$];
  int         epoch = 0;
  int         gap_max = 0;
  int         gap_left = 0;

  always #5 ACLK = ~ACLK;

  uart_tx #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .ACLK         (ACLK),
    .RESET        (RESET),
    .TX_DATA      (tx_data),
    .TX_DATA_VALID(tx_data_valid),
    .TX_READY     (tx_ready),
    .TXD          (txd),
    .TX_BUSY      (tx_busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic void pushFrame(input logic [7:0] b);
    for (int i = 0; i < CPB; i++) m_line.push_back(1'b0);
    for (int n = 0; n < 8; n++)
      for (int i = 0; i < CPB; i++) m_line.push_back(b[n]);
`ifdef UART_TX_PARITY_EN
    for (int i = 0; i < CPB; i++) m_line.push_back(^b);
`endif
    for (int i = 0; i < CPB; i++) m_line.push_back(1'b1);
  endfunction

  task automatic applyStimulus(input logic [7:0] b);
    pending_q.push_back(b);
  endtask

  // One clock edge of the model, using the inputs that were stable before the edge.
  task automatic modelEdge();
    logic hs;
    hs = tx_data_valid && !m_held;
    if (m_line.size() > 0) m_line.delete(0);
    if (m_line.size() == 0 && m_held) begin
      pushFrame(m_hold_byte);
      m_held = 1'b0;
    end
    if (hs) begin
      m_held      = 1'b1;
      m_hold_byte = tx_data;
      sent_q.push_back(tx_data);
      if (pending_q.size() > 0) pending_q.delete(0);
      gap_left = $urandom_range(0, gap_max);
    end
  endtask

  task automatic driveInputs();
    if (pending_q.size() > 0 && gap_left == 0) begin
      tx_data_valid = 1'b1;
      tx_data       = pending_q[0];
    end else begin
      tx_data_valid = 1'b0;
      tx_data       = 8'($urandom);
      if (gap_left > 0) gap_left--;
    end
  endtask

  task automatic runCycles(input int n);
    logic [2:0] exp_v;
    repeat (n) begin
      @(posedge ACLK);
      modelEdge();
      @(negedge ACLK);
      exp_v = {(m_line.size() > 0) ? m_line[0] : 1'b1, !m_held, (m_line.size() > 0) || m_held};
      checkOutput("txd_ready_busy", {29'd0, txd, tx_ready, tx_busy}, {29'd0, exp_v});
      driveInputs();
    end
  endtask

  // Called just after a falling edge; asserts reset mid-cycle and checks it acts at once.
  task automatic pulseReset();
    #2;
    RESET = 1'b1;
    epoch++;
    m_line.delete();
    m_held = 1'b0;
    sent_q.delete();
    pending_q.delete();
    tx_data_valid = 1'b0;
    gap_left = 0;
    #1;
    checkOutput("reset_async", {29'd0, txd, tx_ready, tx_busy}, 32'b110);
    @(posedge ACLK);
    @(negedge ACLK);
    checkOutput("reset_held", {29'd0, txd, tx_ready, tx_busy}, 32'b110);
    RESET = 1'b0;
  endtask

  task automatic drainAll(input string tag);
    int waited;
    logic done;
    waited = 0;
    while ((pending_q.size() > 0 || tx_busy) && waited < 20000) begin
      runCycles(1);
      waited++;
    end
    done = (pending_q.size() == 0) && !tx_busy;
    checkOutput({tag, "_drained"}, {31'd0, done}, 32'd1);
    runCycles(2 * CPB);
    checkOutput({tag, "_all_received"}, sent_q.size(), 32'd0);
  endtask

  task automatic decodeFrame();
    int         ep;
    logic       s[FRAME_BITS];
    logic [7:0] b;
    logic [7:0] exp_b;
    ep = epoch;
    for (int c = 1; c <= (FRAME_BITS - 1) * CPB + CPB / 2; c++) begin
      @(negedge ACLK);
      if (epoch != ep) return;
      if (c % CPB == CPB / 2) s[c / CPB] = txd;
    end
    for (int i = 0; i < 8; i++) b[i] = s[i + 1];
    checkOutput("rx_start", {31'd0, s[0]}, 32'd0);
    checkOutput("rx_stop", {31'd0, s[FRAME_BITS - 1]}, 32'd1);
`ifdef UART_TX_PARITY_EN
    checkOutput("rx_parity", {31'd0, s[9]}, {31'd0, ^b});
`endif
    checkOutput("rx_expected", {31'd0, sent_q.size() > 0}, 32'd1);
    if (sent_q.size() > 0) begin
      exp_b = sent_q.pop_front();
      checkOutput("rx_byte", {24'd0, b}, {24'd0, exp_b});
    end
  endtask

  // Line decoder: independent of the model, it finds start bits and samples mid-bit.
  initial begin
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge ACLK);
      if (RESET) begin
        prev = 1'b1;
      end else if (prev && !txd) begin
        decodeFrame();
        prev = txd;
      end else begin
        prev = txd;
      end
    end
  end

  initial begin
    int waited;
    @(negedge ACLK);
    pulseReset();

    $display("[TB] idle after reset");
    runCycles(200);

    $display("[TB] single byte 0xA5");
    gap_max = 0;
    applyStimulus(8'hA5);
    runCycles(130);
    drainAll("single");

    $display("[TB] back-to-back 0x00, 0xFF");
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    drainAll("b2b");

    $display("[TB] backpressure 0x12, 0x34, 0x56");
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    applyStimulus(8'h56);
    drainAll("backpressure");

    $display("[TB] reset in frame cycle 45");
    applyStimulus(8'h3C);
    applyStimulus(8'h99);
    waited = 0;
    while (txd !== 1'b0 && waited < 50) begin
      runCycles(1);
      waited++;
    end
    checkOutput("frame_started", {31'd0, txd}, 32'd0);
    runCycles(44);
    pulseReset();
    applyStimulus(8'h5A);
    drainAll("after_reset");

    $display("[TB] parity patterns 0x07, 0x03");
    applyStimulus(8'h07);
    applyStimulus(8'h03);
    drainAll("parity");

    $display("[TB] randomized bytes and gaps");
    gap_max = 15;
    for (int i = 0; i < 40; i++) applyStimulus(8'($urandom));
    drainAll("random");

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
